// File: rtl/bitty_pkg.sv
// Shared types and instruction field positions for the Bitty execution unit.
// Encoding: {Rx[15:13], Ry[12:10] | imm[12:5], sel[4:2], fmt[1:0]}.
package bitty_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SRC,
      EXEC,
      WB,
      ERR
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SHL,
      ALU_SHR,
      ALU_CMP
   } alu_op_t;

   localparam logic [1:0] FMT_REG = 2'd0;
   localparam logic [1:0] FMT_IMM = 2'd1;

   localparam int RX_LSB  = 13;
   localparam int RY_LSB  = 10;
   localparam int IMM_LSB = 5;
   localparam int SEL_LSB = 2;
   localparam int FMT_LSB = 0;

endpackage

// File: rtl/bitty_alu_p.sv
// Combinational ALU: add/sub with carry/borrow, logic ops, shifts, unsigned compare.
// Zero latency; no flow control.
module bitty_alu_p
   import bitty_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [2:0]        select,
   output logic [DATA_W-1:0] alu_out,
   output logic              carry
);

   localparam int SH_W = $clog2(DATA_W);

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [SH_W-1:0]   shamt;

   assign sum   = {1'b0, in_a} + {1'b0, in_b};
   assign diff  = {1'b0, in_a} - {1'b0, in_b};
   assign shamt = in_b[SH_W-1:0];

   // diff's top bit is the borrow, i.e. in_a < in_b unsigned
   always_comb begin
      alu_out = '0;
      carry   = 1'b0;
      case (alu_op_t'(select))
         ALU_ADD: begin
            alu_out = sum[DATA_W-1:0];
            carry   = sum[DATA_W];
         end
         ALU_SUB: begin
            alu_out = diff[DATA_W-1:0];
            carry   = diff[DATA_W];
         end
         ALU_AND: alu_out = in_a & in_b;
         ALU_OR:  alu_out = in_a | in_b;
         ALU_XOR: alu_out = in_a ^ in_b;
         ALU_SHL: alu_out = in_a << shamt;
         ALU_SHR: alu_out = in_a >> shamt;
         ALU_CMP: begin
            if (in_a == in_b)     alu_out = '0;
            else if (in_a > in_b) alu_out = DATA_W'(1);
            else                  alu_out = DATA_W'(2);
         end
         default: alu_out = '0;
      endcase
   end

endmodule

// File: rtl/bitty_exec_unit.sv
// Self-sequencing Bitty execution unit with 8-entry register file and preload/debug port.
// Legal instruction completes in 3 cycles (done on the 3rd), illegal in 2; in_ready low while busy.
module bitty_exec_unit
   import bitty_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IMM_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       instruction,
   input  logic              wr_en,
   input  logic [2:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [2:0]        rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] d_out,
   output logic [2:0]        select,
   output logic              flag_z,
   output logic              flag_c,
   output logic              done,
   output logic              err
);

   state_t            state, state_nxt;
   logic [15:0]       reg_i;
   logic [DATA_W-1:0] reg_s;
   logic [DATA_W-1:0] reg_c;
   logic [DATA_W-1:0] regs [8];

   logic [2:0]        rx, ry;
   logic [1:0]        fmt;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] operand;
   logic [DATA_W-1:0] alu_out;
   logic              alu_carry;
   logic              fmt_legal;

   assign rx        = reg_i[RX_LSB +: 3];
   assign ry        = reg_i[RY_LSB +: 3];
   assign imm       = reg_i[IMM_LSB +: IMM_W];
   assign select    = reg_i[SEL_LSB +: 3];
   assign fmt       = reg_i[FMT_LSB +: 2];
   assign fmt_legal = (fmt == FMT_REG) || (fmt == FMT_IMM);

   // Operand is read in EXEC so Rx==Ry sees the value reg_s was latched from
   assign operand = (fmt == FMT_IMM) ? DATA_W'(imm) : regs[ry];
   assign rd_data = regs[rd_addr];
   assign d_out   = reg_c;

   bitty_alu_p #(.DATA_W(DATA_W)) u_alu (
      .in_a    (reg_s),
      .in_b    (operand),
      .select  (select),
      .alu_out (alu_out),
      .carry   (alu_carry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = SRC;
         end
         SRC:  state_nxt = fmt_legal ? EXEC : ERR;
         EXEC: state_nxt = WB;
         WB: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         ERR: begin
            done      = 1'b1;
            err       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_i  <= '0;
         reg_s  <= '0;
         reg_c  <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else begin
         if (state == IDLE && in_valid) reg_i <= instruction;
         if (state == SRC)              reg_s <= regs[rx];
         if (state == EXEC) begin
            reg_c  <= alu_out;
            flag_z <= (alu_out == '0);
            flag_c <= alu_carry;
         end
      end
   end

   // Preload and write-back never collide: preload only lands while idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (state == WB) begin
         regs[rx] <= reg_c;
      end else if (wr_en && in_ready) begin
         regs[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_bitty_exec_unit.sv
// Bench for bitty_exec_unit: directed scenarios plus random instructions against a
// behavioural model of the register file and ALU.
module tb_bitty_exec_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] instruction;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] d_out;
   logic [2:0]  select;
   logic        flag_z, flag_c, done, err;

   int checks = 0;
   int errors = 0;

   logic [15:0] model [8];
   logic [15:0] exp_dout;
   logic        exp_z, exp_c, exp_err;
   int          exp_lat;

   bitty_exec_unit #(.DATA_W(16), .IMM_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .d_out       (d_out),
      .select      (select),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] enc(input logic [2:0] rx, input logic [7:0] f,
                                       input logic [2:0] sel, input logic [1:0] fmt);
      logic [4:0] junk;
      junk = 5'($urandom);
      if (fmt == 2'd1) return {rx, f, sel, fmt};
      return {rx, f[2:0], junk, sel, fmt};
   endfunction

   // Reference ALU on plain unsigned integers modulo 2^16
   function automatic void ref_alu(input int unsigned x, input int unsigned y, input int sel,
                                   output int unsigned r, output logic c);
      c = 1'b0;
      case (sel)
         0: begin r = (x + y) % 65536; c = ((x + y) >= 65536); end
         1: begin r = (x + 65536 - y) % 65536; c = (x < y); end
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: r = (x << (y % 16)) % 65536;
         6: r = x >> (y % 16);
         default: r = (x == y) ? 0 : ((x > y) ? 1 : 2);
      endcase
   endfunction

   task automatic model_exec(input logic [15:0] ins);
      int unsigned x, y, r;
      logic        c;
      int          rx, ry, sel, fmt;
      rx  = int'(ins[15:13]);
      ry  = int'(ins[12:10]);
      sel = int'(ins[4:2]);
      fmt = int'(ins[1:0]);
      if (fmt > 1) begin
         exp_err = 1'b1;
         exp_lat = 2;
         return;
      end
      exp_err = 1'b0;
      exp_lat = 3;
      x = model[rx];
      y = (fmt == 0) ? model[ry] : int'(ins[12:5]);
      ref_alu(x, y, sel, r, c);
      model[rx] = r[15:0];
      exp_dout  = r[15:0];
      exp_z     = (r == 0);
      exp_c     = c;
   endtask

   task automatic preload(input int addr, input logic [15:0] data);
      wr_en   = 1'b1;
      wr_addr = addr[2:0];
      wr_data = data;
      tick();
      wr_en = 1'b0;
      model[addr] = data;
   endtask

   // Offers one instruction while idle; reports cycle number of done (T0+n) and state after
   task automatic run(input logic [15:0] ins, output int lat, output logic err_seen,
                      output logic rdy_after);
      model_exec(ins);
      instruction = ins;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      wr_en    = 1'b0;
      lat      = -1;
      err_seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (done === 1'b1) begin
            lat      = k + 1;
            err_seen = err;
            break;
         end
         tick();
      end
      tick();
      rdy_after = in_ready;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      checks++;
      if ({in_ready, done, err, flag_z, flag_c} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 10000", {in_ready, done, err, flag_z, flag_c});
      end
      checks++;
      if (d_out !== 16'h0 || select !== 3'd0) begin
         errors++;
         $display("FAIL reset_dout_sel: got %h/%0d expected 0000/0", d_out, select);
      end
      reset = 1'b0;
      tick();
      for (int a = 0; a < 8; a++) begin
         model[a] = '0;
         rd_addr = a[2:0];
         #1;
         checks++;
         if (rd_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_reg R%0d: got %h expected 0000", a, rd_data);
         end
      end
      exp_dout = '0; exp_z = 1'b0; exp_c = 1'b0;
   endtask

   task automatic test_add();
      int lat; logic e, r;
      preload(1, 16'd5);
      preload(2, 16'd3);
      run(enc(3'd1, 8'd2, 3'd0, 2'd0), lat, e, r);
      checks++;
      if (lat !== 3 || e !== 1'b0) begin
         errors++;
         $display("FAIL add_timing: got lat %0d err %b expected lat 3 err 0", lat, e);
      end
      checks++;
      if (d_out !== 16'd8 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
         errors++;
         $display("FAIL add_result: got %h z%b c%b expected 0008 z0 c0", d_out, flag_z, flag_c);
      end
      rd_addr = 3'd1;
      #1;
      checks++;
      if (rd_data !== 16'd8 || r !== 1'b1) begin
         errors++;
         $display("FAIL add_wb: got R1 %h ready %b expected 0008 ready 1", rd_data, r);
      end
   endtask

   task automatic test_sub_cmp_imm();
      int lat; logic e, r;
      preload(3, 16'h0010);
      run(enc(3'd3, 8'h20, 3'd1, 2'd1), lat, e, r);
      rd_addr = 3'd3;
      #1;
      checks++;
      if (d_out !== 16'hFFF0 || rd_data !== 16'hFFF0 || flag_c !== 1'b1 || lat !== 3) begin
         errors++;
         $display("FAIL sub_imm: got %h R3 %h c%b lat %0d expected fff0 fff0 c1 lat 3",
                  d_out, rd_data, flag_c, lat);
      end
      run(enc(3'd3, 8'hF0, 3'd7, 2'd1), lat, e, r);
      checks++;
      if (d_out !== 16'd1 || flag_c !== 1'b0) begin
         errors++;
         $display("FAIL cmp_imm: got %h c%b expected 0001 c0", d_out, flag_c);
      end
   endtask

   task automatic test_shl_carry();
      int lat; logic e, r;
      preload(4, 16'h0001);
      preload(5, 16'd17);
      run(enc(3'd4, 8'd5, 3'd5, 2'd0), lat, e, r);
      rd_addr = 3'd4;
      #1;
      checks++;
      if (rd_data !== 16'h0002) begin
         errors++;
         $display("FAIL shl_mod: got R4 %h expected 0002", rd_data);
      end
      preload(6, 16'hFFFF);
      preload(7, 16'h0001);
      run(enc(3'd6, 8'd7, 3'd0, 2'd0), lat, e, r);
      rd_addr = 3'd6;
      #1;
      checks++;
      if (rd_data !== 16'h0 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
         errors++;
         $display("FAIL add_wrap: got R6 %h z%b c%b expected 0000 z1 c1", rd_data, flag_z, flag_c);
      end
   endtask

   task automatic test_illegal();
      int lat; logic e, r;
      logic [15:0] prev_dout; logic prev_z, prev_c;
      for (int f = 2; f < 4; f++) begin
         prev_dout = d_out; prev_z = flag_z; prev_c = flag_c;
         run(enc(3'd1, 8'd2, 3'd0, f[1:0]), lat, e, r);
         checks++;
         if (lat !== 2 || e !== 1'b1 || r !== 1'b1) begin
            errors++;
            $display("FAIL illegal_fmt%0d: got lat %0d err %b ready %b expected 2 1 1", f, lat, e, r);
         end
         checks++;
         if (d_out !== prev_dout || flag_z !== prev_z || flag_c !== prev_c) begin
            errors++;
            $display("FAIL illegal_state: got %h z%b c%b expected %h z%b c%b",
                     d_out, flag_z, flag_c, prev_dout, prev_z, prev_c);
         end
      end
      for (int a = 0; a < 8; a++) begin
         rd_addr = a[2:0];
         #1;
         checks++;
         if (rd_data !== model[a]) begin
            errors++;
            $display("FAIL illegal_regs R%0d: got %h expected %h", a, rd_data, model[a]);
         end
      end
   endtask

   task automatic test_preload_same_edge();
      int lat; logic e, r;
      preload(2, 16'h0100);
      wr_en   = 1'b1;
      wr_addr = 3'd2;
      wr_data = 16'h1234;
      model[2] = 16'h1234;
      run(enc(3'd2, 8'h01, 3'd0, 2'd1), lat, e, r);
      checks++;
      if (d_out !== 16'h1235) begin
         errors++;
         $display("FAIL same_edge_preload: got %h expected 1235", d_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] prog [3];
      int acc_t [3];
      int n_acc;
      logic acc;
      preload(1, 16'h0007);
      preload(2, 16'h0009);
      prog[0] = enc(3'd1, 8'd2, 3'd0, 2'd0);
      prog[1] = enc(3'd1, 8'd3, 3'd1, 2'd1);
      prog[2] = enc(3'd2, 8'd1, 3'd4, 2'd0);
      for (int i = 0; i < 3; i++) begin
         model_exec(prog[i]);
         acc_t[i] = -100;
      end
      n_acc       = 0;
      instruction = prog[0];
      in_valid    = 1'b1;
      for (int t = 0; t < 16; t++) begin
         acc     = in_ready && in_valid;
         wr_en   = ~in_ready;
         wr_addr = 3'($urandom);
         wr_data = 16'($urandom);
         tick();
         if (acc) begin
            acc_t[n_acc] = t;
            n_acc++;
            if (n_acc == 3) in_valid = 1'b0;
            else            instruction = prog[n_acc];
         end
      end
      wr_en = 1'b0;
      checks++;
      if (n_acc !== 3 || acc_t[1] - acc_t[0] !== 4 || acc_t[2] - acc_t[1] !== 4) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d accepts at %0d,%0d,%0d expected 3 spaced by 4",
                  n_acc, acc_t[0], acc_t[1], acc_t[2]);
      end
      for (int a = 0; a < 8; a++) begin
         rd_addr = a[2:0];
         #1;
         checks++;
         if (rd_data !== model[a]) begin
            errors++;
            $display("FAIL b2b_regs R%0d: got %h expected %h", a, rd_data, model[a]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int lat; logic e, r;
      int done_seen;
      preload(1, 16'h0011);
      preload(2, 16'h0022);
      instruction = enc(3'd1, 8'd2, 3'd0, 2'd0);
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      reset     = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (done === 1'b1) done_seen++;
         tick();
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || d_out !== 16'h0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state: got ready %b dout %h z%b c%b expected 1 0000 0 0",
                  in_ready, d_out, flag_z, flag_c);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen !== 0) begin
         errors++;
         $display("FAIL rst_mid_done: got %0d done pulses expected 0", done_seen);
      end
      for (int a = 0; a < 8; a++) begin
         model[a] = '0;
         rd_addr = a[2:0];
         #1;
         checks++;
         if (rd_data !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid_reg R%0d: got %h expected 0000", a, rd_data);
         end
      end
      preload(0, 16'h4000);
      run(enc(3'd0, 8'd0, 3'd0, 2'd0), lat, e, r);
      rd_addr = 3'd0;
      #1;
      checks++;
      if (lat !== 3 || rd_data !== 16'h8000 || d_out !== 16'h8000) begin
         errors++;
         $display("FAIL rst_mid_recover: got lat %0d R0 %h dout %h expected 3 8000 8000",
                  lat, rd_data, d_out);
      end
   endtask

   task automatic test_random();
      int lat; logic e, r;
      logic [15:0] ins;
      logic [1:0]  fmt;
      logic [15:0] prev_dout; logic prev_z, prev_c;
      for (int n = 0; n < 30; n++) begin
         preload($urandom_range(0, 7), 16'($urandom));
         if ($urandom_range(0, 1) == 1) preload($urandom_range(0, 7), 16'($urandom_range(0, 3)));
         fmt = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
         ins = enc(3'($urandom), 8'($urandom), 3'($urandom), fmt);
         prev_dout = d_out; prev_z = flag_z; prev_c = flag_c;
         run(ins, lat, e, r);
         if (exp_err) begin
            exp_dout = prev_dout; exp_z = prev_z; exp_c = prev_c;
         end
         checks++;
         if (lat !== exp_lat || e !== exp_err || r !== 1'b1 || select !== ins[4:2]) begin
            errors++;
            $display("FAIL rand%0d_ctrl ins %h: got lat %0d err %b ready %b sel %0d expected %0d %b 1 %0d",
                     n, ins, lat, e, r, select, exp_lat, exp_err, ins[4:2]);
         end
         checks++;
         if (d_out !== exp_dout || flag_z !== exp_z || flag_c !== exp_c) begin
            errors++;
            $display("FAIL rand%0d_result ins %h: got %h z%b c%b expected %h z%b c%b",
                     n, ins, d_out, flag_z, flag_c, exp_dout, exp_z, exp_c);
         end
         rd_addr = ins[15:13];
         #1;
         checks++;
         if (rd_data !== model[ins[15:13]]) begin
            errors++;
            $display("FAIL rand%0d_wb ins %h: got %h expected %h", n, ins, rd_data, model[ins[15:13]]);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      instruction = '0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      rd_addr     = '0;
      test_reset();
      test_add();
      test_sub_cmp_imm();
      test_shl_carry();
      test_illegal();
      test_preload_same_edge();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bitty_exec_unit.md
# bitty_exec_unit

Self-sequencing, width-parametrised execution unit for the Bitty processor. It accepts one 16-bit instruction at a time over a valid/ready handshake. Internally it generates the instruction-latch, source-latch, result-latch and register-write enables with an FSM, so no external enable sequencer is needed. It holds the 8-entry register file, supports register and immediate formats, flags illegal formats, and exposes a preload/debug port for the testbench and the future fetch stage.

## Interface
- DATA_W, 16, datapath and register width (≥ 8)
- IMM_W, 8, immediate field width taken from instr[12:5], zero-extended to DATA_W (fixed 8 for 16-bit encoding)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  unit idle and able to accept; reset 1
- instruction  in  16  {Rx[15:13], Ry[12:10] / imm[12:5], sel[4:2], fmt[1:0]}
- wr_en  in  1  preload write to register file
- wr_addr  in  3  preload address
- wr_data  in  DATA_W  preload data
- rd_addr  in  3  debug read address
- rd_data  out  DATA_W  combinational R[rd_addr]; reset 0
- d_out  out  DATA_W  last ALU result (reg_c); reset 0
- select  out  3  sel of latched instruction; reset 0
- flag_z  out  1  reg_c == 0 after EXEC; reset 0
- flag_c  out  1  carry (ADD) / borrow (SUB) after EXEC, else 0; reset 0
- done  out  1  one-cycle pulse at completion; reset 0
- err  out  1  one-cycle pulse with done for illegal fmt; reset 0

## Operation
- The FSM has 5 states: IDLE, SRC, EXEC, WB, ERR.
- IDLE:
  - in_ready=1.
  - When in_valid, latch reg_i and go to SRC.
  - A wr_en in the same cycle is accepted.
- SRC:
  - reg_s <= R[Rx].
  - If fmt is 0 or 1, go to EXEC; if fmt is 2 or 3, go to ERR.
- EXEC:
  - The operand is R[Ry] when fmt=0, or zero-extended imm when fmt=1.
  - reg_c <= alu(reg_s, operand, sel). flag_z and flag_c update here.
- WB: R[Rx] <= reg_c; done=1; go to IDLE.
- ERR: done=1, err=1; no register, reg_c or flag update; go to IDLE.
- ALU sel encoding (DATA_W-bit modular arithmetic):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL by operand[$clog2(DATA_W)-1:0]; 6 SHR (logical) by the same field.
  - 7 CMP: result 0 if equal, 1 if x>y, 2 if x<y, all unsigned.
- Carry is bit DATA_W of the (DATA_W+1)-bit sum. Borrow is 1 when x<y unsigned.
- wr_en is honoured only while in_ready=1 and ignored otherwise.
- A preload to Rx accepted on the instruction-accept edge is visible to that instruction, because SRC reads in the next cycle.
- R0 is an ordinary writable register.
- Rx==Ry is legal; the operand is read in EXEC, after reg_s was latched.

## Timing
- Accept edge is T0. The states run SRC at T0+1, EXEC at T0+2, WB at T0+3.
- done is high during T0+3, and R[Rx] holds the result from edge T0+4.
- d_out is valid from the end of EXEC (T0+3) and holds until the next EXEC.
- Throughput is one instruction per 4 cycles. in_ready is high again at T0+4, and a back-to-back accept on that edge is allowed.
- An illegal instruction completes with done and err high at T0+2.
- rd_data is combinational. A write at edge k is visible after edge k.
- Reset at any point:
  - The FSM goes to IDLE, and all registers, reg_i, reg_s and reg_c clear to 0.
  - done, err and flags go to 0, and in_ready goes to 1.
  - An in-flight instruction is dropped with no done.

## Structure
- Package bitty_pkg:
  - state_t enum (IDLE, SRC, EXEC, WB, ERR).
  - alu_op_t enum (ADD..CMP).
  - FMT_REG=0 and FMT_IMM=1 constants.
  - Instruction field position localparams.
- Sub-module bitty_alu_p #(DATA_W):
  - Inputs in_a, in_b, select.
  - Outputs alu_out and carry.
  - Purely combinational, instantiated once.

## Test plan
- Preload R1=5, R2=3; send ADD R1,R2 (fmt 0, sel 0) -> done at T0+3, d_out=8, R1=8, flag_z=0, flag_c=0.
- R3=0x0010; send SUB R3, imm 0x20 (fmt 1, sel 1) -> R3=0xFFF0, flag_c=1. Then CMP R3, imm 0xF0 -> d_out=1.
- R4=0x0001; SHL R4 by R5=17 (DATA_W=16) -> shift uses 4 bits, so shift is 1, giving R4=0x0002. ADD R6=0xFFFF + R7=1 -> R6=0, flag_z=1, flag_c=1.
- Send fmt=2 -> done and err together at T0+2; all registers, d_out and flags unchanged; in_ready high at T0+3.
- Hold in_valid high across 3 instructions -> accepts spaced exactly 4 cycles apart. wr_en during busy cycles leaves the register file unchanged.
- Assert reset at T0+2 of an ADD -> no done pulse, every rd_addr reads 0, in_ready=1 next cycle. A new instruction then executes normally.
